tpu_out_writer: RTL
===================

# tpu_out_writer

Write-back stage directly downstream of the TPU `top`. It consumes the 256-bit result words that `top` emits on `gbuff_out` and `out_valid`, buffers them in a small FIFO, and writes them to the output global-buffer SRAM at sequential addresses. The SRAM may stall the writer through a valid/ready handshake. The block counts results against the job shape (`m`, `n`), raises `done` when the last word has been written, and flags any word it has to drop.

## Interface
Parameters:
- `ADDR_W`, default 10: SRAM word-address width.
- `FIFO_DEPTH`, default 4: result FIFO depth. Must be a power of two, at least 2.

Ports:
- `clk`, in, 1: single clock. Everything is sampled on the rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: one-cycle job start. Sampled only in IDLE.
- `m`, in, 5: output rows. Captured on `start`.
- `n`, in, 5: output columns. Captured on `start`.
- `k`, in, 5: reduction depth. Captured and ignored; it is carried for interface parity with `top`.
- `base_addr`, in, `ADDR_W`: first SRAM address. Captured on `start`.
- `out_valid`, in, 1: result word valid, from `top`.
- `gbuff_out`, in, 256: result word, from `top`.
- `sram_wen`, out, 1: write request valid.
- `sram_addr`, out, `ADDR_W`: write address.
- `sram_wdata`, out, 256: write data.
- `sram_ready`, in, 1: SRAM accepts the write in this cycle.
- `busy`, out, 1: high in RUN and DRAIN.
- `done`, out, 1: one-cycle completion pulse.
- `err`, out, 1: sticky drop flag. Cleared by an accepted `start`.

## Operation
Words expected per job:
- `total = m * ceil(n/8)`, computed as `m * ((n+7)>>3)`.
- `total` is 7 bits unsigned, maximum 124. Each word carries 8 lanes of 32 bits.

State machine (IDLE, RUN, DRAIN, DONE):
- IDLE, `start`=1:
  - Capture the configuration.
  - Clear `err`, the receive count and the write count.
  - Next state is DONE if `total`==0, otherwise RUN.
- RUN:
  - Push each `out_valid` word and increment the receive count.
  - When the receive count reaches `total`, go to DRAIN.
- DRAIN: when the FIFO is empty and the write count equals `total`, go to DONE.
- DONE: `done`=1 for exactly this cycle, then go to IDLE.
- `start` outside IDLE is ignored and has no effect on `err`.

FIFO:
- Push condition: `out_valid` in RUN and receive count < `total`.
- When full, the push still succeeds if a pop happens in the same cycle.
- When full with no pop, the word is dropped: `err` is set and the receive count does not advance.
- `out_valid` in IDLE, DRAIN or DONE drops the word and sets `err`.
  - Exception: after a job, `err` stays clear until the next `start` only if no such word occurs.

Output register (holds `sram_wen`, `sram_addr`, `sram_wdata`):
- A transfer happens on any cycle with `sram_wen` && `sram_ready`.
- The register loads from the FIFO head when it is empty, or when it transfers in the same cycle.
- While `sram_wen`=1 and `sram_ready`=0, address and data are held stable.
- `sram_addr` = `base_addr` + write index. It wraps modulo 2^`ADDR_W`.
- The write count increments on each transfer.

Reset (asynchronous, any state, including mid-job):
- Returns to IDLE and empties the FIFO.
- `sram_wen`, `busy`, `done`, `err` = 0.
- `sram_addr` and `sram_wdata` = 0.
- No partial write is completed after reset.

## Timing
- `start` at cycle t: `busy`=1 from t+1.
- With `total`==0: `done`=1 at t+1, `busy` stays 0.
- With `sram_ready` high:
  - `out_valid` word at cycle t appears with `sram_wen`=1 at t+2.
  - Throughput is one word per cycle.
- The final transfer at cycle t gives `done`=1 at t+2 (DRAIN exit at t+1). `busy` falls with `done`.
- `err` rises the cycle after the dropping edge.

## Test plan
- Basic job: `m`=4, `n`=8, `base_addr`=0x10, `sram_ready`=1. Send 4 consecutive words D0..D3.
  - Expect writes to 0x10..0x13 in order, at cycles 2..5 after the first word.
  - Expect `done` once, `err`=0.
- Tile rounding: `m`=3, `n`=9, giving `total`=6. Send 6 words.
  - Expect 6 writes, then `done`.
  - A 7th `out_valid` after `done` sets `err`=1.
- Back-pressure: `m`=8, `n`=8, `FIFO_DEPTH`=4, `sram_ready`=0 for 6 cycles. Send 8 words back-to-back.
  - Expect the word in the output register held stable.
  - Expect 4 words in the FIFO and 1 word dropped, with `err`=1.
  - Expect 7 writes in order, after which the job stays in RUN until the 8th word arrives.
- Empty job: `m`=0, `n`=5. Expect `done` at t+1, `busy` never high, `sram_wen` never high.
- Address wrap: `ADDR_W`=10, `base_addr`=0x3FE, 4 words. Expect addresses 0x3FE, 0x3FF, 0x000, 0x001.
- Reset mid-job: `m`=8, `n`=8. Assert `rst_n`=0 asynchronously after 3 writes.
  - Expect all outputs 0 immediately.
  - Expect the next `start` job to complete normally from `base_addr`.

Source files
------------

// File: rtl/tpu_out_writer.sv
// Write-back stage for TPU results: buffers result words in a small FIFO and
// streams them to the output SRAM at sequential addresses with stall support.
//
// state | meaning
// IDLE  | waiting for start; any incoming word is dropped
// RUN   | accepting result words until total have been received
// DRAIN | all words received; emptying FIFO and output register
// DONE  | one-cycle completion pulse
module tpu_out_writer #(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4:0]        m,
  input  logic [4:0]        n,
  input  logic [4:0]        k,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              out_valid,
  input  logic [255:0]      gbuff_out,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [255:0]      sram_wdata,
  input  logic              sram_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic [6:0]        total_q;
  logic [6:0]        rx_cnt;
  logic [6:0]        wr_cnt;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] ld_idx;
  logic [4:0]        k_unused_q;

  logic [255:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [PW:0]       count;

  logic [5:0] n_round;
  logic [6:0] total_in;
  logic       start_acc;
  logic       fifo_empty;
  logic       fifo_full;
  logic       xfer;
  logic       pop;
  logic       push;
  logic       drop;

  // ceil(n/8) tiles of 8 lanes per output row
  assign n_round    = {1'b0, n} + 6'd7;
  assign total_in   = {2'b00, m} * {4'b0000, n_round[5:3]};
  assign start_acc  = (state == IDLE) && start;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign xfer       = sram_wen && sram_ready;
  assign pop        = !fifo_empty && (!sram_wen || sram_ready);
  assign push       = out_valid && (state == RUN) && (rx_cnt < total_q) && (!fifo_full || pop);
  assign drop       = out_valid && !push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      total_q    <= '0;
      base_q     <= '0;
      k_unused_q <= '0;
      rx_cnt     <= '0;
      wr_cnt     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (push) rx_cnt <= rx_cnt + 7'd1;
      if (xfer) wr_cnt <= wr_cnt + 7'd1;
      case (state)
        IDLE: begin
          if (start) begin
            total_q    <= total_in;
            base_q     <= base_addr;
            k_unused_q <= k;
            rx_cnt     <= '0;
            wr_cnt     <= '0;
            err        <= 1'b0;
            if (total_in == 7'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (push && (rx_cnt + 7'd1 == total_q)) state <= DRAIN;
        end
        DRAIN: begin
          if (fifo_empty && (wr_cnt == total_q)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      // a drop in the start cycle still counts against the new job
      if (drop) err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= gbuff_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_wen   <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      ld_idx     <= '0;
    end else begin
      if (pop) begin
        sram_wen   <= 1'b1;
        sram_addr  <= base_q + ld_idx;
        sram_wdata <= mem[rptr];
      end else if (xfer) begin
        sram_wen <= 1'b0;
      end
      if (start_acc)  ld_idx <= '0;
      else if (pop)   ld_idx <= ld_idx + ADDR_W'(1);
    end
  end

endmodule
